fetcher: RTL

FETCHER -- requirements
Module: fetcher

---
 rtl/fetcher_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetcher.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetcher_pkg.sv
// Shared constants and types for the instruction fetcher: opcodes, queue sizing,
// branch-predictor tag width, FSM states and the queue entry layout.
package fetcher_pkg;

  localparam int BP_TAG_WIDTH    = 4;
  localparam int IQ_SIZE_DEFAULT = 8;
  localparam int IQ_IDX_WIDTH    = $clog2(IQ_SIZE_DEFAULT);

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: head/tail pointers plus an occupancy count.
// Clear wins over push/pop; the parent never pushes when full or pops when empty.
module fetch_queue
  import fetcher_pkg::*;
#(
  parameter int DEPTH = IQ_SIZE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [31:0]              push_inst,
  input  logic [31:0]              push_pc,
  input  logic                     push_pred,
  output logic [31:0]              head_inst,
  output logic [31:0]              head_pc,
  output logic                     head_pred,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  iq_entry_t     mem [DEPTH];

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + IW'(1);
      if (pop)  head <= head + IW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is defined solely by count.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{inst: push_inst, pc: push_pc, pred: push_pred};
  end

  assign head_inst = mem[head].inst;
  assign head_pc   = mem[head].pc;
  assign head_pred = mem[head].pred;

endmodule

// File: rtl/fetcher.sv
// Instruction fetcher: one-outstanding icache request FSM, JAL/branch predecode
// with predictor lookup, and an instruction queue feeding dispatch.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int          IQ_SIZE  = IQ_SIZE_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  output logic                    out_icache_ce,
  output logic [31:0]             out_icache_pc,
  input  logic                    in_icache_ce,
  input  logic [31:0]             in_icache_inst,
  output logic [BP_TAG_WIDTH-1:0] out_bp_tag,
  input  logic                    in_bp_jump_ce,
  output logic                    out_dispatch_ce,
  output logic [31:0]             out_dispatch_inst,
  output logic [31:0]             out_dispatch_pc,
  output logic                    out_dispatch_pred_jump,
  input  logic                    in_dispatch_stall,
  input  logic                    in_rob_flush_ce,
  input  logic [31:0]             in_rob_target_pc
);

  localparam int CW = $clog2(IQ_SIZE) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [CW-1:0] iq_count;
  logic          iq_push, iq_pop, iq_clear;
  logic [31:0]   imm_j, imm_b;
  logic [31:0]   pred_pc;
  logic          pred_jump;

  assign out_icache_pc   = pc;
  assign out_bp_tag      = pc[2 +: BP_TAG_WIDTH];
  assign out_dispatch_ce = (iq_count != '0);
  assign iq_pop          = rdy && out_dispatch_ce && !in_dispatch_stall;

  assign imm_j = {{12{in_icache_inst[31]}}, in_icache_inst[19:12], in_icache_inst[20],
                  in_icache_inst[30:21], 1'b0};
  assign imm_b = {{20{in_icache_inst[31]}}, in_icache_inst[7], in_icache_inst[30:25],
                  in_icache_inst[11:8], 1'b0};

  // Static prediction: JAL always taken, branches follow the predictor, JALR falls through.
  always_comb begin
    pred_pc   = pc + 32'd4;
    pred_jump = FALSE;
    case (in_icache_inst[6:0])
      OPC_JAL: begin
        pred_pc   = pc + imm_j;
        pred_jump = TRUE;
      end
      OPC_BRANCH: begin
        if (in_bp_jump_ce) begin
          pred_pc   = pc + imm_b;
          pred_jump = TRUE;
        end
      end
      default: ;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    out_icache_ce = FALSE;
    iq_push       = FALSE;
    iq_clear      = FALSE;
    if (rdy) begin
      if (in_rob_flush_ce) begin
        iq_clear  = TRUE;
        pc_nxt    = in_rob_target_pc;
        // A request still in flight must have its response swallowed later.
        state_nxt = (state != IDLE && !in_icache_ce) ? DISCARD : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (iq_count < CW'(IQ_SIZE)) begin
              out_icache_ce = TRUE;
              state_nxt     = WAIT;
            end
          end
          WAIT: begin
            if (in_icache_ce) begin
              iq_push   = TRUE;
              pc_nxt    = pred_pc;
              state_nxt = IDLE;
            end
          end
          DISCARD: begin
            if (in_icache_ce) state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
    // A request issued during reset would be forgotten by the reset transition.
    if (rst) out_icache_ce = FALSE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ((state == WAIT || state == DISCARD) && !in_icache_ce) ? DISCARD : IDLE;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  fetch_queue #(.DEPTH(IQ_SIZE)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (iq_push),
    .pop       (iq_pop),
    .clear     (iq_clear),
    .push_inst (in_icache_inst),
    .push_pc   (pc),
    .push_pred (pred_jump),
    .head_inst (out_dispatch_inst),
    .head_pc   (out_dispatch_pc),
    .head_pred (out_dispatch_pred_jump),
    .count     (iq_count)
  );

endmodule
